fp_max_abs_stream: RTL and testbench
====================================

Name: fp_max_abs_stream

Overview:
Streaming reduction stage that consumes a frame of IEEE floating-point samples and returns the largest magnitude, its position and the frame length. It sits directly downstream of the precision-library magnitude logic (sign clear) and feeds normalisation/scaling blocks that need the peak magnitude of a vector. Valid/ready handshake on both sides, one result per frame. Supports the same HALF/SINGLE precision selection as the rest of the library.

Parameters:
BITS, 16, sample width; 16 for HALF, 32 for SINGLE
PRECISION, "HALF", "HALF" or "SINGLE"; selects exponent/mantissa field positions
MAX_LEN, 256, maximum frame length in samples; power of two, >= 2
IDX_W, $clog2(MAX_LEN), width of the index output (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input sample valid
in_ready  output  1  block accepts a sample this cycle
in_data  input  BITS  floating-point sample; sign bit ignored
in_last  input  1  marks final sample of the frame
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_max  output  BITS  peak magnitude, sign bit always 0
out_index  output  IDX_W  zero-based position of the peak within the frame
out_count  output  IDX_W+1  number of samples in the frame (1..MAX_LEN)
out_trunc  output  1  frame was force-closed at MAX_LEN without in_last

Behaviour:
- Reset (async assert, sync deassert expected upstream): state IDLE, out_valid=0, out_max=0, out_index=0, out_count=0, out_trunc=0, in_ready=1 after reset drops.
- Beat accepted when in_valid & in_ready.
- Magnitude compare: unsigned compare of in_data[BITS-2:0] against the held max. This is correct IEEE ordering for non-NaN values, including subnormals and inf.
- Ties: strictly-greater replaces, so the earliest index wins.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: in_ready=1. The first beat loads max={0,in_data[BITS-2:0]}, index=0, count=1, trunc=0. Next state is HOLD if in_last, else ACCUM.
- ACCUM: in_ready=1. Each beat: count+1; position=count before the increment; max and index update on strictly-greater. The frame closes on a beat with in_last, or on the beat that makes count==MAX_LEN (sets trunc=1 if in_last=0). On close, next state is HOLD.
- HOLD: in_ready=0, out_valid=1. Outputs are registered and stable while out_valid & !out_ready. On out_ready, next state is IDLE and out_valid drops the next cycle.
- Latency: out_valid rises the cycle after the closing beat is accepted. Minimum frame period is N beats + 1 HOLD cycle. No overlap: the next frame's first beat is accepted no earlier than the cycle after the handshake.
- in_last on the first beat gives a single-sample frame: count=1, index=0.
- in_last together with count reaching MAX_LEN gives trunc=0 (legal full-length frame).
- Reset mid-frame or mid-HOLD discards all state immediately; no partial result is emitted.
- Field positions: HALF exp[14:10], mant[9:0]; SINGLE exp[30:23], mant[22:0]. Used only by the optional feature.

Optional Feature:
Macro FP_MAX_ABS_NAN_EN.
- Defined:
  - Any accepted NaN (exponent all ones, mantissa nonzero) sets a sticky frame flag.
  - At close, out_max is forced to the canonical quiet NaN: HALF 16'h7E00, SINGLE 32'h7FC00000.
  - out_index holds the position of the first NaN.
  - Extra output out_nan (1 bit) is asserted with the result and reset to 0.
- Undefined:
  - No out_nan port.
  - NaN is compared as raw bits, so it wins over inf by bit ordering; its payload passes through with the sign cleared.

Test Plan:
- HALF frame 3C00, C000, 4000, 3800 (last on the 4th beat) -> out_max=4000, out_index=1, out_count=4, out_trunc=0.
- Single beat C400 with in_last -> one cycle later out_valid=1, out_max=4400, out_index=0, out_count=1.
- SINGLE frame 3F800000, FF800000, 00000001 (last) -> out_max=7F800000, out_index=1, out_count=3.
- MAX_LEN=4, five beats 1,2,3,4,5 with no in_last -> result after beat 4: out_max=4, out_index=3, out_count=4, out_trunc=1. The 5th beat starts a new frame.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> in_ready=0 and outputs constant throughout. Handshake, then IDLE the next cycle.
- Reset asserted after 2 beats -> outputs zero immediately. A new 2-beat frame 3C00, 3800 -> out_max=3C00, index 0, count 2.
- With FP_MAX_ABS_NAN_EN, HALF frame 3C00, 7C01, 7C00 -> out_max=7E00, out_index=1, out_nan=1.

Source files
------------

// File: rtl/fp_max_abs_stream.sv
// Streaming peak-magnitude reducer: one result (max |x|, position, length) per frame.
// Optional NaN tracking via `define FP_MAX_ABS_NAN_EN (adds out_nan, forces canonical qNaN result).
module fp_max_abs_stream #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    MAX_LEN   = 256,
    parameter int    IDX_W     = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_max,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W:0]   out_count,
`ifdef FP_MAX_ABS_NAN_EN
    output logic             out_nan,
`endif
    output logic             out_trunc
);

    generate
        if (!((PRECISION == "HALF" && BITS == 16) || (PRECISION == "SINGLE" && BITS == 32))) begin : g_bad_cfg
            $error("fp_max_abs_stream: BITS/PRECISION combination not supported");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t           state_q;
    logic [BITS-1:0]  max_q;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W:0]   count_q;
    logic             trunc_q;

    logic             accept;
    logic [BITS-2:0]  mag;
    logic             greater;
    logic [IDX_W:0]   count_d;
    logic             full;
    logic [IDX_W-1:0] pos;
    logic             unused_sign;

    assign unused_sign = in_data[BITS-1];
    assign in_ready    = (state_q != S_HOLD);
    assign out_valid   = (state_q == S_HOLD);
    assign accept      = in_valid && in_ready;
    assign mag         = in_data[BITS-2:0];
    // Raw unsigned compare of the sign-cleared bits matches IEEE magnitude order.
    assign greater     = (mag > max_q[BITS-2:0]);
    assign count_d     = count_q + 1'b1;
    assign full        = (count_d == (IDX_W+1)'(MAX_LEN));
    assign pos         = count_q[IDX_W-1:0];

    assign out_max     = max_q;
    assign out_index   = index_q;
    assign out_count   = count_q;
    assign out_trunc   = trunc_q;

`ifdef FP_MAX_ABS_NAN_EN
    localparam int EXP_W  = (PRECISION == "SINGLE") ? 8 : 5;
    localparam int MANT_W = BITS - 1 - EXP_W;
    localparam logic [BITS-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    logic nan_q;
    logic is_nan;

    assign is_nan  = (&in_data[BITS-2 -: EXP_W]) && (|in_data[MANT_W-1:0]);
    assign out_nan = nan_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            max_q   <= '0;
            index_q <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
`ifdef FP_MAX_ABS_NAN_EN
            nan_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        max_q   <= {1'b0, mag};
                        index_q <= '0;
                        count_q <= (IDX_W+1)'(1);
                        trunc_q <= 1'b0;
`ifdef FP_MAX_ABS_NAN_EN
                        nan_q   <= is_nan;
                        if (is_nan) max_q <= QNAN;
`endif
                        state_q <= in_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        count_q <= count_d;
`ifdef FP_MAX_ABS_NAN_EN
                        // Once a NaN is seen the result is fixed to qNaN at its first position.
                        if (!nan_q) begin
                            if (is_nan) begin
                                nan_q   <= 1'b1;
                                max_q   <= QNAN;
                                index_q <= pos;
                            end else if (greater) begin
                                max_q   <= {1'b0, mag};
                                index_q <= pos;
                            end
                        end
`else
                        if (greater) begin
                            max_q   <= {1'b0, mag};
                            index_q <= pos;
                        end
`endif
                        if (in_last || full) begin
                            trunc_q <= !in_last;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_max_abs_stream.sv
// Directed bench for fp_max_abs_stream: HALF/256, SINGLE/256 and HALF/4 instances.
// NaN checks follow `define FP_MAX_ABS_NAN_EN.
module tb_fp_max_abs_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        last;
    logic        ordy;
    logic        vh, vs, vt;

    logic        rdy_h, ov_h, tr_h, nan_h;
    logic [15:0] max_h;
    logic [7:0]  idx_h;
    logic [8:0]  cnt_h;

    logic        rdy_s, ov_s, tr_s, nan_s;
    logic [31:0] max_s;
    logic [7:0]  idx_s;
    logic [8:0]  cnt_s;

    logic        rdy_t, ov_t, tr_t, nan_t;
    logic [15:0] max_t;
    logic [1:0]  idx_t;
    logic [2:0]  cnt_t;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_max_abs_stream #(.BITS(16), .PRECISION("HALF"), .MAX_LEN(256)) u_h (
        .clk(clk), .reset(reset), .in_valid(vh), .in_ready(rdy_h), .in_data(din[15:0]),
        .in_last(last), .out_valid(ov_h), .out_ready(ordy), .out_max(max_h),
        .out_index(idx_h), .out_count(cnt_h),
`ifdef FP_MAX_ABS_NAN_EN
        .out_nan(nan_h),
`endif
        .out_trunc(tr_h)
    );

    fp_max_abs_stream #(.BITS(32), .PRECISION("SINGLE"), .MAX_LEN(256)) u_s (
        .clk(clk), .reset(reset), .in_valid(vs), .in_ready(rdy_s), .in_data(din),
        .in_last(last), .out_valid(ov_s), .out_ready(ordy), .out_max(max_s),
        .out_index(idx_s), .out_count(cnt_s),
`ifdef FP_MAX_ABS_NAN_EN
        .out_nan(nan_s),
`endif
        .out_trunc(tr_s)
    );

    fp_max_abs_stream #(.BITS(16), .PRECISION("HALF"), .MAX_LEN(4)) u_t (
        .clk(clk), .reset(reset), .in_valid(vt), .in_ready(rdy_t), .in_data(din[15:0]),
        .in_last(last), .out_valid(ov_t), .out_ready(ordy), .out_max(max_t),
        .out_index(idx_t), .out_count(cnt_t),
`ifdef FP_MAX_ABS_NAN_EN
        .out_nan(nan_t),
`endif
        .out_trunc(tr_t)
    );

`ifndef FP_MAX_ABS_NAN_EN
    assign nan_h = 1'b0;
    assign nan_s = 1'b0;
    assign nan_t = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One accepted beat on the selected instance (0=half, 1=single, 2=len4).
    task automatic beat(input int sel, input logic [31:0] d, input logic l);
        @(negedge clk);
        din  = d;
        last = l;
        vh   = (sel == 0);
        vs   = (sel == 1);
        vt   = (sel == 2);
        @(posedge clk);
        #1;
        vh = 1'b0; vs = 1'b0; vt = 1'b0; last = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
    endtask

    initial begin
        reset = 1'b1; din = '0; last = 1'b0; ordy = 1'b0;
        vh = 1'b0; vs = 1'b0; vt = 1'b0;

        @(negedge clk);
        chk("rst_valid", 64'(ov_h), 64'd0);
        chk("rst_max",   64'(max_h), 64'd0);
        chk("rst_count", 64'(cnt_h), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(rdy_h), 64'd1);
        chk("rst_index", 64'(idx_h), 64'd0);
        chk("rst_trunc", 64'(tr_h),  64'd0);
        chk("rst_nan",   64'(nan_h), 64'd0);

        // Tie on 4000 vs |C000|: earliest wins.
        beat(0, 32'h3C00, 1'b0);
        beat(0, 32'hC000, 1'b0);
        beat(0, 32'h4000, 1'b0);
        beat(0, 32'h3800, 1'b1);
        @(negedge clk);
        chk("f1_valid", 64'(ov_h),  64'd1);
        chk("f1_max",   64'(max_h), 64'h4000);
        chk("f1_index", 64'(idx_h), 64'd1);
        chk("f1_count", 64'(cnt_h), 64'd4);
        chk("f1_trunc", 64'(tr_h),  64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(ov_h),  64'd1);
            chk("bp_ready", 64'(rdy_h), 64'd0);
            chk("bp_max",   64'(max_h), 64'h4000);
            chk("bp_index", 64'(idx_h), 64'd1);
        end
        handshake();
        @(negedge clk);
        chk("hs_valid", 64'(ov_h),  64'd0);
        chk("hs_ready", 64'(rdy_h), 64'd1);

        beat(0, 32'hC400, 1'b1);
        @(negedge clk);
        chk("single_valid", 64'(ov_h),  64'd1);
        chk("single_max",   64'(max_h), 64'h4400);
        chk("single_index", 64'(idx_h), 64'd0);
        chk("single_count", 64'(cnt_h), 64'd1);
        handshake();

        beat(0, 32'h4000, 1'b0);
        beat(0, 32'h4400, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_max",   64'(max_h), 64'd0);
        chk("midrst_count", 64'(cnt_h), 64'd0);
        chk("midrst_valid", 64'(ov_h),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        beat(0, 32'h3C00, 1'b0);
        beat(0, 32'h3800, 1'b1);
        @(negedge clk);
        chk("post_max",   64'(max_h), 64'h3C00);
        chk("post_index", 64'(idx_h), 64'd0);
        chk("post_count", 64'(cnt_h), 64'd2);
        chk("post_valid", 64'(ov_h),  64'd1);
        reset = 1'b1;
        #1;
        chk("holdrst_valid", 64'(ov_h),  64'd0);
        chk("holdrst_max",   64'(max_h), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        beat(1, 32'h3F800000, 1'b0);
        beat(1, 32'hFF800000, 1'b0);
        beat(1, 32'h00000001, 1'b1);
        @(negedge clk);
        chk("sgl_valid", 64'(ov_s),  64'd1);
        chk("sgl_max",   64'(max_s), 64'h7F800000);
        chk("sgl_index", 64'(idx_s), 64'd1);
        chk("sgl_count", 64'(cnt_s), 64'd3);
        handshake();

        beat(2, 32'h1, 1'b0);
        beat(2, 32'h2, 1'b0);
        beat(2, 32'h3, 1'b0);
        beat(2, 32'h4, 1'b0);
        @(negedge clk);
        chk("tr_valid", 64'(ov_t),  64'd1);
        chk("tr_ready", 64'(rdy_t), 64'd0);
        chk("tr_max",   64'(max_t), 64'h4);
        chk("tr_index", 64'(idx_t), 64'd3);
        chk("tr_count", 64'(cnt_t), 64'd4);
        chk("tr_trunc", 64'(tr_t),  64'd1);
        handshake();
        beat(2, 32'h5, 1'b1);
        @(negedge clk);
        chk("tr5_max",   64'(max_t), 64'h5);
        chk("tr5_index", 64'(idx_t), 64'd0);
        chk("tr5_count", 64'(cnt_t), 64'd1);
        chk("tr5_trunc", 64'(tr_t),  64'd0);
        handshake();
        beat(2, 32'h7, 1'b0);
        beat(2, 32'h2, 1'b0);
        beat(2, 32'h9, 1'b0);
        beat(2, 32'h1, 1'b1);
        @(negedge clk);
        chk("full_max",   64'(max_t), 64'h9);
        chk("full_index", 64'(idx_t), 64'd2);
        chk("full_count", 64'(cnt_t), 64'd4);
        chk("full_trunc", 64'(tr_t),  64'd0);
        handshake();

        beat(0, 32'h3C00, 1'b0);
        beat(0, 32'h7C01, 1'b0);
        beat(0, 32'h7C00, 1'b1);
        @(negedge clk);
        chk("nan_valid", 64'(ov_h),  64'd1);
        chk("nan_index", 64'(idx_h), 64'd1);
`ifdef FP_MAX_ABS_NAN_EN
        chk("nan_max",  64'(max_h), 64'h7E00);
        chk("nan_flag", 64'(nan_h), 64'd1);
`else
        chk("nan_raw_max", 64'(max_h), 64'h7C01);
`endif
        handshake();
        @(negedge clk);
        chk("end_valid", 64'(ov_h), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
